// File: rtl/inst_fetch.sv
// Instruction fetch stage with a direct-mapped I-cache. It delivers hits in one cycle,
// fetches misses from memory, and accepts fills of prefetched words.
module inst_fetch #(
   parameter int unsigned ICACHE_ENTRIES = 16,
   parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        jump_i,
   input  logic [31:0] jump_pc_i,
   input  logic [31:0] mem_inst_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_ok_i,
   output logic        fe_o,
   output logic [31:0] fpc_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        valid_o
);

   localparam int unsigned IDX   = $clog2(ICACHE_ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX;

   typedef enum logic {S_FETCH, S_MISS} state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [31:0]               r_pc;
   logic                      r_fe;
   logic [31:0]               r_pc_o;
   logic [31:0]               r_inst_o;
   logic                      r_valid_o;
   logic [ICACHE_ENTRIES-1:0] r_line_valid;
   logic [TAG_W-1:0]          r_tag  [ICACHE_ENTRIES];
   logic [31:0]               r_data [ICACHE_ENTRIES];

   logic [IDX-1:0]            w_idx;
   logic [IDX-1:0]            w_fill_idx;
   logic                      w_hit;
   logic                      w_ret_match;
   logic                      w_deliver;
   logic [31:0]               w_del_pc;
   logic [31:0]               w_del_inst;
   logic [31:0]               w_next_pc;

   assign w_idx       = r_pc[IDX+1:2];
   assign w_fill_idx  = mem_pc_i[IDX+1:2];
   assign w_hit       = r_line_valid[w_idx] && (r_tag[w_idx] == r_pc[31:IDX+2]);
   assign w_ret_match = mem_ok_i && (mem_pc_i[31:2] == r_pc[31:2]);

   // Next state, next PC and delivery selection; a redirect overrides everything
   always_comb begin
      w_next_state = r_state;
      w_deliver    = 1'b0;
      w_del_pc     = r_pc;
      w_del_inst   = r_data[w_idx];
      w_next_pc    = r_pc;
      if (jump_i) begin
         w_next_state = S_FETCH;
         w_next_pc    = {jump_pc_i[31:2], 2'b00};
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_hit) begin
                  if (!stall_i) begin
                     w_deliver = 1'b1;
                     w_next_pc = r_pc + 32'd4;
                  end
               end else begin
                  w_next_state = S_MISS;
               end
            end
            S_MISS: begin
               if (w_ret_match) begin
                  // A stalled return only fills; the following FETCH cycle hits it
                  w_next_state = S_FETCH;
                  if (!stall_i) begin
                     w_deliver  = 1'b1;
                     w_del_pc   = {mem_pc_i[31:2], 2'b00};
                     w_del_inst = mem_inst_i;
                     w_next_pc  = r_pc + 32'd4;
                  end
               end
            end
            default: w_next_state = S_FETCH;
         endcase
      end
   end

   // State register; fe_o is a flop mirroring the MISS state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_fe    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_fe    <= (w_next_state == S_MISS);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= {RESET_PC[31:2], 2'b00};
         r_valid_o <= 1'b0;
         r_pc_o    <= 32'd0;
         r_inst_o  <= 32'd0;
      end else begin
         r_pc <= w_next_pc;
         if (jump_i) begin
            r_valid_o <= 1'b0;
         end else if (w_deliver) begin
            r_valid_o <= 1'b1;
            r_pc_o    <= w_del_pc;
            r_inst_o  <= w_del_inst;
         end else if (!stall_i) begin
            r_valid_o <= 1'b0;
         end
      end
   end

   // Every memory return fills its line, whether or not it is delivered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_line_valid <= '0;
      end else if (mem_ok_i) begin
         r_line_valid[w_fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_ok_i) begin
         r_tag[w_fill_idx]  <= mem_pc_i[31:IDX+2];
         r_data[w_fill_idx] <= mem_inst_i;
      end
   end

   assign fe_o    = r_fe;
   assign fpc_o   = r_pc;
   assign pc_o    = r_pc_o;
   assign inst_o  = r_inst_o;
   assign valid_o = r_valid_o;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed checks plus a scoreboard of expected deliveries.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        jump_i;
   logic [31:0] jump_pc_i;
   logic [31:0] mem_inst_i;
   logic [31:0] mem_pc_i;
   logic        mem_ok_i;
   logic        fe_o;
   logic [31:0] fpc_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        valid_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic prev_adv = 1'b0;

   inst_fetch #(.ICACHE_ENTRIES(16), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall_i),
      .jump_i     (jump_i),
      .jump_pc_i  (jump_pc_i),
      .mem_inst_i (mem_inst_i),
      .mem_pc_i   (mem_pc_i),
      .mem_ok_i   (mem_ok_i),
      .fe_o       (fe_o),
      .fpc_o      (fpc_o),
      .pc_o       (pc_o),
      .inst_o     (inst_o),
      .valid_o    (valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // A fresh delivery is valid_o high after an edge that was neither stalled, redirected nor reset
   always @(posedge clk) prev_adv = !stall_i && !jump_i && !rst;

   always @(negedge clk) begin
      if (valid_o && prev_adv) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_valid", {31'd0, valid_o}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_pc", pc_o, e.pc);
            check("sb_inst", inst_o, e.inst);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      sb_q.push_back(e);
   endtask

   task automatic ret(input logic [31:0] pc, input logic [31:0] inst);
      mem_ok_i   = 1'b1;
      mem_pc_i   = pc;
      mem_inst_i = inst;
      cyc();
      mem_ok_i   = 1'b0;
   endtask

   task automatic jump_to(input logic [31:0] pc);
      jump_i    = 1'b1;
      jump_pc_i = pc;
      cyc();
      jump_i    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_pc_i = '0;
      mem_inst_i = '0; mem_pc_i = '0; mem_ok_i = 1'b0;
      cyc(); cyc();
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_pc_o", pc_o, 32'd0);
      check("rst_inst_o", inst_o, 32'd0);
      check("rst_fe", {31'd0, fe_o}, 32'd0);
      check("rst_fpc", fpc_o, 32'd0);
      rst = 1'b0;

      // Cold start
      cyc();
      check("cold_fe", {31'd0, fe_o}, 32'd1);
      check("cold_fpc", fpc_o, 32'd0);
      repeat (4) cyc();
      check("cold_fe_hold", {31'd0, fe_o}, 32'd1);
      push(32'h0, 32'h0000_0013);
      ret(32'h0, 32'h0000_0013);
      check("cold_valid", {31'd0, valid_o}, 32'd1);
      check("cold_fpc_next", fpc_o, 32'd4);

      // Fill 0x4..0xC
      for (int a = 4; a <= 12; a += 4) begin
         cyc();
         check("fill_fe", {31'd0, fe_o}, 32'd1);
         push(32'(a), 32'hA000_0000 | 32'(a));
         ret(32'(a), 32'hA000_0000 | 32'(a));
      end

      // Warm loop
      jump_to(32'h0);
      check("warm_jump_valid", {31'd0, valid_o}, 32'd0);
      push(32'h0, 32'h0000_0013);
      for (int a = 4; a <= 12; a += 4) push(32'(a), 32'hA000_0000 | 32'(a));
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("warm_valid", {31'd0, valid_o}, 32'd1);
         check("warm_fe", {31'd0, fe_o}, 32'd0);
      end

      // Stall on return
      jump_to(32'h20);
      cyc();
      check("stall_miss_fe", {31'd0, fe_o}, 32'd1);
      stall_i = 1'b1;
      ret(32'h20, 32'hB000_0020);
      check("stall_ret_valid", {31'd0, valid_o}, 32'd0);
      check("stall_ret_fe", {31'd0, fe_o}, 32'd0);
      check("stall_ret_fpc", fpc_o, 32'h20);
      cyc();
      check("stall_hold_valid", {31'd0, valid_o}, 32'd0);
      stall_i = 1'b0;
      push(32'h20, 32'hB000_0020);
      cyc();
      check("stall_rel_valid", {31'd0, valid_o}, 32'd1);
      check("stall_rel_fpc", fpc_o, 32'h24);
      stall_i = 1'b1;
      cyc();
      check("stall_out_hold_valid", {31'd0, valid_o}, 32'd1);
      check("stall_out_hold_pc", pc_o, 32'h20);
      check("stall_miss_anyway", {31'd0, fe_o}, 32'd1);
      stall_i = 1'b0;

      // Redirect mid-miss
      jump_to(32'h40);
      cyc();
      check("redir_miss_fe", {31'd0, fe_o}, 32'd1);
      check("redir_miss_fpc", fpc_o, 32'h40);
      jump_to(32'h103);
      check("redir_fpc", fpc_o, 32'h100);
      check("redir_valid", {31'd0, valid_o}, 32'd0);
      check("redir_fe", {31'd0, fe_o}, 32'd0);
      ret(32'h40, 32'hC000_0040);
      check("late_ret_valid", {31'd0, valid_o}, 32'd0);
      check("late_ret_fpc", fpc_o, 32'h100);
      jump_to(32'h40);
      push(32'h40, 32'hC000_0040);
      cyc();
      check("late_fill_hit", {31'd0, valid_o}, 32'd1);

      // Conflict: 0x40 evicted 0x0
      jump_to(32'h0);
      cyc();
      check("conflict_miss", {31'd0, fe_o}, 32'd1);
      push(32'h0, 32'h0000_0013);
      ret(32'h0, 32'h0000_0013);
      push(32'h4, 32'hA000_0004);
      cyc();
      check("conflict_next_hit", {31'd0, valid_o}, 32'd1);

      // Reset during MISS
      jump_to(32'h80);
      cyc();
      check("rstmiss_fe", {31'd0, fe_o}, 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rstmiss_fe_low", {31'd0, fe_o}, 32'd0);
      check("rstmiss_valid", {31'd0, valid_o}, 32'd0);
      check("rstmiss_pc_o", pc_o, 32'd0);
      check("rstmiss_fpc", fpc_o, 32'd0);

      // Prefetch fill
      jump_to(32'h8);
      cyc();
      check("pref_miss_fe", {31'd0, fe_o}, 32'd1);
      ret(32'hC, 32'hD000_000C);
      check("pref_fill_fe", {31'd0, fe_o}, 32'd1);
      check("pref_fill_valid", {31'd0, valid_o}, 32'd0);
      push(32'h8, 32'hD000_0008);
      ret(32'h8, 32'hD000_0008);
      push(32'hC, 32'hD000_000C);
      cyc();
      check("pref_hit_valid", {31'd0, valid_o}, 32'd1);

      // PC wrap
      jump_to(32'hFFFF_FFFC);
      cyc();
      push(32'hFFFF_FFFC, 32'hE000_0001);
      ret(32'hFFFF_FFFC, 32'hE000_0001);
      check("wrap_fpc", fpc_o, 32'h0);

      // Jump beats a simultaneous matching return
      cyc();
      check("jret_miss_fe", {31'd0, fe_o}, 32'd1);
      mem_ok_i = 1'b1; mem_pc_i = 32'h0; mem_inst_i = 32'hF000_0000;
      jump_to(32'h200);
      mem_ok_i = 1'b0;
      check("jret_valid", {31'd0, valid_o}, 32'd0);
      check("jret_fpc", fpc_o, 32'h200);
      jump_to(32'h0);
      push(32'h0, 32'hF000_0000);
      cyc();
      check("jret_fill_hit", {31'd0, valid_o}, 32'd1);

      cyc(); cyc();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ICACHE_ENTRIES, default 16, number of direct-mapped I-cache lines (power of two, 4..256).
REQ-002 Parameter RESET_PC, default 32'h00000000, fetch PC after reset.
REQ-003 clk  in  1  system clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 stall_i  in  1  decode stage cannot accept an instruction this cycle.
REQ-006 jump_i  in  1  redirect request from execute (branch or jump taken).
REQ-007 jump_pc_i  in  32  redirect target.
REQ-008 mem_inst_i  in  32  instruction word returned by the memory controller.
REQ-009 mem_pc_i  in  32  address of mem_inst_i.
REQ-010 mem_ok_i  in  1  one-cycle pulse; mem_inst_i and mem_pc_i valid.
REQ-011 fe_o  out  1  fetch request to the memory controller.
REQ-012 fpc_o  out  32  requested fetch address; equals the internal PC at all times.
REQ-013 pc_o  out  32  address of the delivered instruction.
REQ-014 inst_o  out  32  delivered instruction word.
REQ-015 valid_o  out  1  pc_o/inst_o hold a new instruction for decode.

Function
REQ-016 PC register: bits [1:0] always 0; jump_pc_i[1:0] discarded on load.
REQ-017 Cache line: valid bit, tag PC[31:2+IDX], 32-bit data, where IDX=log2(ICACHE_ENTRIES), indexed by PC[IDX+1:2]; hit is combinational from current PC.
REQ-018 FSM states FETCH and MISS; fe_o is asserted only in MISS, registered-state decoded, glitch-free.
REQ-019 FETCH, hit, !stall_i, !jump_i: next edge valid_o=1, pc_o=PC, inst_o=line data, PC<=PC+4; hit-to-output latency is 1 cycle, with back-to-back hits delivering one instruction per cycle.
REQ-020 FETCH, miss, !jump_i: go to MISS next edge, regardless of stall_i.
REQ-021 MISS: PC held; fe_o=1 and fpc_o=PC held stable until the matching return, a jump, or reset.
REQ-022 Any cycle with mem_ok_i=1: write mem_inst_i into the line selected by mem_pc_i, set its valid bit and tag, even if mem_pc_i differs from PC (prefetched word).
REQ-023 MISS, mem_ok_i=1, mem_pc_i==PC, !stall_i, !jump_i: deliver mem_inst_i/mem_pc_i on the outputs with valid_o=1, PC<=PC+4, and go to FETCH.
REQ-024 MISS, matching return with stall_i=1: fill the line, go to FETCH, no delivery, PC held; the next unstalled FETCH cycle hits.
REQ-025 MISS, mem_ok_i with mem_pc_i!=PC: fill only, and remain in MISS.
REQ-026 stall_i=1 with no jump: pc_o, inst_o, valid_o and PC hold their values.
REQ-027 !stall_i and no delivery this cycle: valid_o<=0 (bubble).
REQ-028 jump_i=1 in any state, with priority over stall_i and memory returns: PC<=jump_pc_i & ~3, valid_o<=0, state<=FETCH; a simultaneous mem_ok_i still fills the cache but is never delivered.
REQ-029 Redirect wins in MISS: fe_o is low for the following cycle, and a late return for the old PC only fills the cache.
REQ-030 PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-031 No coherence with data stores: the I-cache is not invalidated by memory writes.

Reset
REQ-032 rst=1 at an edge: PC=RESET_PC, state=FETCH, all cache valid bits=0, valid_o=0, pc_o=0, inst_o=0; cache tag/data contents are don't-care.
REQ-033 The first cycle after rst deasserts is a FETCH cycle that misses, so fe_o=1 appears one cycle later.
REQ-034 rst asserted during MISS abandons the request; fe_o=0 the next cycle and later mem_ok_i pulses fill only.

Verification
REQ-035 Cold start: release rst, memory returns 0x00000013 at pc 0 after 5 cycles -> fe_o=1 with fpc_o=0, then valid_o=1, pc_o=0, inst_o=0x00000013, fpc_o=4.
REQ-036 Warm loop: after filling 0x0..0xC, jump_pc_i=0x0 -> four consecutive valid_o cycles with pc_o 0,4,8,C and fe_o=0 throughout.
REQ-037 Stall on return: stall_i=1 while mem_ok_i delivers pc 0x20 -> outputs hold; release stall -> next cycle valid_o=1, pc_o=0x20.
REQ-038 Redirect mid-miss: in MISS at pc 0x40, jump_i to 0x103 -> fpc_o=0x100, valid_o=0; a late return for 0x40 sets only line index 0 and its data is not delivered.
REQ-039 Conflict: fill 0x0, then fetch 0x40 (same index, 16 entries) -> miss, refill; refetch 0x0 -> miss.
REQ-040 Prefetch fill: in MISS at 0x8, mem_ok_i with pc 0xC and then 0x8 -> deliver 0x8, then 0xC hits next cycle.
